// File: rtl/spi_slave_param.sv
// SPI slave with a configurable word length and SPI mode. The bus signals are
// synchronised into clk, with a one-word tx buffer, an rx holding register and
// sticky overrun/underrun flags.
module spi_slave_param #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              underrun,
  input  logic              clr_err
);

  localparam int unsigned CNT_W       = $clog2(DATA_W + 1);
  localparam logic        IDLE_SCLK   = (CPOL != 0);
  localparam bit          SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      txbuf_q, txbuf_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  // from_buf: current word came from the buffer; und_pend: current word is a zero fill
  logic                   from_buf_q, from_buf_d;
  logic                   und_pend_q, und_pend_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, sample_stb, shift_stb, cs_fall, word_done;
  logic ovr_set, und_set;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign sample_stb = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_stb  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign cs_fall    = cs_prev_q & ~cs_s;
  assign word_done  = (bit_cnt_q == CNT_W'(DATA_W));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    txbuf_d    = txbuf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    from_buf_d = from_buf_q;
    und_pend_d = und_pend_q;
    ovr_set    = 1'b0;
    und_set    = 1'b0;

    if (tx_load && tx_ready_q) begin
      txbuf_d    = tx_data;
      tx_ready_d = 1'b0;
    end
    if (rx_ack) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cs_s) begin
          state_d = IDLE;
        end else begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          if (!tx_ready_q) begin
            tx_shift_d = txbuf_q;
            tx_ready_d = 1'b1;
            from_buf_d = 1'b1;
            und_pend_d = 1'b0;
          end else begin
            tx_shift_d = '0;
            from_buf_d = 1'b0;
            und_pend_d = 1'b1;
          end
          if (CPHA == 0) begin
            miso_d = ~tx_ready_q & txbuf_q[DATA_W-1];
          end
        end
      end
      SHIFT: begin
        if (word_done) begin
          if (rx_valid_q && !rx_ack) begin
            ovr_set = 1'b1;
          end else begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
          from_buf_d = 1'b0;
          und_pend_d = 1'b0;
          state_d    = cs_s ? IDLE : LOAD;
        end else if (cs_s) begin
          // aborted word: its buffered data goes back unless the host refilled it
          state_d = IDLE;
          if (from_buf_q && tx_ready_q) begin
            tx_ready_d = 1'b0;
          end
        end else begin
          if (sample_stb) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (und_pend_q && (bit_cnt_q == '0)) begin
              und_set    = 1'b1;
              und_pend_d = 1'b0;
            end
          end
          if (shift_stb) begin
            if ((CPHA != 0) && (bit_cnt_q == '0)) begin
              miso_d = tx_shift_q[DATA_W-1];
            end else if (bit_cnt_q != '0) begin
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_d     = tx_shift_q[DATA_W-2];
            end else begin
              miso_d = miso_q;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      from_buf_d = 1'b0;
      und_pend_d = 1'b0;
      miso_d     = 1'b0;
      miso_oe_d  = 1'b0;
    end else begin
      miso_oe_d = 1'b1;
    end

    overrun_d  = ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    underrun_d = und_set ? 1'b1 : (clr_err ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE_SCLK}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= IDLE_SCLK;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      txbuf_q     <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      from_buf_q  <= 1'b0;
      und_pend_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      txbuf_q     <= txbuf_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      from_buf_q  <= from_buf_d;
      und_pend_q  <= und_pend_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: one instance per SPI mode, a bit-level master and
// a word-level model of the tx buffer, rx register and error flags.
module tb_spi_slave_param;
  localparam int W = 16;
  localparam int H = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0] sclk_v, cs_n_v, mosi_v, miso_v, oe_v, tx_load_v, tx_ready_v;
  logic [3:0] rx_valid_v, rx_ack_v, ovr_v, und_v, clr_v;
  logic [3:0][W-1:0] tx_data_v, rx_data_v;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_slave_param #(.DATA_W(W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .sclk(sclk_v[g]), .cs_n(cs_n_v[g]), .mosi(mosi_v[g]),
        .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(tx_data_v[g]), .tx_load(tx_load_v[g]),
        .tx_ready(tx_ready_v[g]), .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]),
        .rx_ack(rx_ack_v[g]), .overrun(ovr_v[g]), .underrun(und_v[g]), .clr_err(clr_v[g]));
    end
  endgenerate

  int nvec = 0;
  int nerr = 0;

  int rise_cnt [4] = '{default: 0};
  logic [3:0] rxv_prev = 4'b0;
  always @(posedge clk) begin
    rxv_prev <= rx_valid_v;
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_v[i] && !rxv_prev[i]) rise_cnt[i] <= rise_cnt[i] + 1;
    end
  end

  // word-level reference model, one entry per mode
  bit         m_rxv [4];
  logic [W-1:0] m_rxd [4];
  bit         m_ovr [4];
  bit         m_und [4];
  bit         m_txf [4];
  logic [W-1:0] m_txw [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rxv[i] = 0; m_rxd[i] = '0; m_ovr[i] = 0; m_und[i] = 0; m_txf[i] = 0; m_txw[i] = '0;
    end
  endtask

  task automatic model_word(input int m, input logic [W-1:0] rxw, output logic [W-1:0] exp_miso);
    exp_miso = m_txf[m] ? m_txw[m] : '0;
    if (!m_txf[m]) m_und[m] = 1;
    m_txf[m] = 0;
    if (m_rxv[m]) m_ovr[m] = 1;
    else begin m_rxd[m] = rxw; m_rxv[m] = 1; end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [W-1:0] w);
    tx_data_v[m] = w; tx_load_v[m] = 1'b1;
    tick(1);
    tx_load_v[m] = 1'b0;
    if (!m_txf[m]) begin m_txf[m] = 1; m_txw[m] = w; end
  endtask

  task automatic ack(input int m);
    rx_ack_v[m] = 1'b1; tick(1); rx_ack_v[m] = 1'b0; tick(1);
    m_rxv[m] = 0;
  endtask

  task automatic clr(input int m);
    clr_v[m] = 1'b1; tick(1); clr_v[m] = 1'b0; tick(1);
    m_ovr[m] = 0; m_und[m] = 0;
  endtask

  task automatic send_bits(input int m, input logic [W-1:0] w, input int nbits, output logic [W-1:0] rd);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_v[m] = w[W-1-i]; tick(H);
        rd = {rd[W-2:0], miso_v[m]};
        sclk_v[m] = ~cpol; tick(H);
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol; mosi_v[m] = w[W-1-i]; tick(H);
        rd = {rd[W-2:0], miso_v[m]};
        sclk_v[m] = cpol; tick(H);
      end
    end
  endtask

  task automatic frame(input int m, input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                       input int nbits_last, output logic [W-1:0] r0, output logic [W-1:0] r1);
    cs_n_v[m] = 1'b0; tick(8);
    r1 = '0;
    send_bits(m, w0, (n == 1) ? nbits_last : W, r0);
    if (n > 1) send_bits(m, w1, nbits_last, r1);
    tick(H); cs_n_v[m] = 1'b1; tick(10);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(3);
    model_reset();
    for (int m = 0; m < 4; m++) begin
      nvec++;
      if ({miso_v[m], oe_v[m], tx_ready_v[m], rx_valid_v[m], ovr_v[m], und_v[m]} !== 6'b001000) begin
        nerr++; $display("FAIL reset_flags mode%0d: got %b want 001000", m,
          {miso_v[m], oe_v[m], tx_ready_v[m], rx_valid_v[m], ovr_v[m], und_v[m]});
      end
      nvec++;
      if (rx_data_v[m] !== 16'h0000) begin nerr++; $display("FAIL reset_rx_data mode%0d: got %h want 0000", m, rx_data_v[m]); end
    end
  endtask

  task automatic test_modes();
    logic [W-1:0] r0, r1, e0;
    int rc;
    for (int m = 0; m < 4; m++) begin
      load_tx(m, 16'hA5C3);
      nvec++;
      if (tx_ready_v[m] !== 1'b0) begin nerr++; $display("FAIL tx_ready_drop mode%0d: got %b want 0", m, tx_ready_v[m]); end
      rc = rise_cnt[m];
      frame(m, 1, 16'h1234, 16'h0000, W, r0, r1);
      model_word(m, 16'h1234, e0);
      nvec++;
      if (r0 !== e0) begin nerr++; $display("FAIL miso_word mode%0d: got %h want %h", m, r0, e0); end
      nvec++;
      if (rx_data_v[m] !== m_rxd[m]) begin nerr++; $display("FAIL rx_data mode%0d: got %h want %h", m, rx_data_v[m], m_rxd[m]); end
      nvec++;
      if (rise_cnt[m] - rc !== 1) begin nerr++; $display("FAIL rx_valid_rises mode%0d: got %0d want 1", m, rise_cnt[m] - rc); end
      nvec++;
      if ({rx_valid_v[m], ovr_v[m], und_v[m], tx_ready_v[m], oe_v[m]} !== 5'b10010) begin
        nerr++; $display("FAIL flags mode%0d: got %b want 10010", m, {rx_valid_v[m], ovr_v[m], und_v[m], tx_ready_v[m], oe_v[m]});
      end
      ack(m);
      nvec++;
      if (rx_valid_v[m] !== 1'b0) begin nerr++; $display("FAIL rx_ack mode%0d: got %b want 0", m, rx_valid_v[m]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, c, r0, r1, e0, e1;
    for (int k = 0; k < 2; k++) begin
      int m;
      m = (k == 0) ? 0 : 3;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      load_tx(m, a);
      frame(m, 2, b, c, W, r0, r1);
      model_word(m, b, e0);
      model_word(m, c, e1);
      nvec++;
      if (r0 !== e0) begin nerr++; $display("FAIL b2b_miso0 mode%0d: got %h want %h", m, r0, e0); end
      nvec++;
      if (r1 !== e1) begin nerr++; $display("FAIL b2b_miso1 mode%0d: got %h want %h", m, r1, e1); end
      nvec++;
      if ({rx_data_v[m], und_v[m], ovr_v[m]} !== {m_rxd[m], m_und[m], m_ovr[m]}) begin
        nerr++; $display("FAIL b2b_rx_flags mode%0d: got %h/%b%b want %h/%b%b", m,
          rx_data_v[m], und_v[m], ovr_v[m], m_rxd[m], m_und[m], m_ovr[m]);
      end
      clr(m); ack(m);
      nvec++;
      if ({ovr_v[m], und_v[m], rx_valid_v[m]} !== 3'b000) begin
        nerr++; $display("FAIL b2b_clear mode%0d: got %b want 000", m, {ovr_v[m], und_v[m], rx_valid_v[m]});
      end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] w1, w2, r0, r1, e0;
    w1 = W'($urandom); w2 = ~w1;
    frame(1, 1, w1, 16'h0000, W, r0, r1); model_word(1, w1, e0);
    frame(1, 1, w2, 16'h0000, W, r0, r1); model_word(1, w2, e0);
    nvec++;
    if (rx_data_v[1] !== m_rxd[1]) begin nerr++; $display("FAIL ovr_rx_data: got %h want %h", rx_data_v[1], m_rxd[1]); end
    nvec++;
    if (ovr_v[1] !== m_ovr[1]) begin nerr++; $display("FAIL ovr_flag: got %b want %b", ovr_v[1], m_ovr[1]); end
    clr(1);
    nvec++;
    if ({ovr_v[1], und_v[1]} !== 2'b00) begin nerr++; $display("FAIL ovr_clr: got %b want 00", {ovr_v[1], und_v[1]}); end
    ack(1);
  endtask

  task automatic test_abort();
    logic [W-1:0] t, r0, r1, e0;
    t = W'($urandom) | 16'h8001;
    load_tx(2, t);
    frame(2, 1, 16'hFE00, 16'h0000, 7, r0, r1);
    nvec++;
    if ({rx_valid_v[2], tx_ready_v[2], und_v[2], oe_v[2]} !== 4'b0000) begin
      nerr++; $display("FAIL abort_state: got %b want 0000", {rx_valid_v[2], tx_ready_v[2], und_v[2], oe_v[2]});
    end
    frame(2, 1, 16'h00FF, 16'h0000, W, r0, r1);
    model_word(2, 16'h00FF, e0);
    nvec++;
    if (rx_data_v[2] !== 16'h00FF) begin nerr++; $display("FAIL abort_rx: got %h want 00ff", rx_data_v[2]); end
    nvec++;
    if (r0 !== e0) begin nerr++; $display("FAIL abort_miso: got %h want %h", r0, e0); end
    ack(2);
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] r0, r1, e0, w;
    w = W'($urandom) | 16'h0100;
    frame(3, 1, w, 16'h0000, W, r0, r1);
    load_tx(3, 16'h5A5A);
    cs_n_v[3] = 1'b0; tick(8);
    send_bits(3, 16'hFFFF, 5, r0);
    rst = 1'b1; #1;
    nvec++;
    if ({miso_v[3], oe_v[3], tx_ready_v[3], rx_valid_v[3], ovr_v[3], und_v[3]} !== 6'b001000) begin
      nerr++; $display("FAIL rst_mid_flags: got %b want 001000",
        {miso_v[3], oe_v[3], tx_ready_v[3], rx_valid_v[3], ovr_v[3], und_v[3]});
    end
    nvec++;
    if (rx_data_v[3] !== 16'h0000) begin nerr++; $display("FAIL rst_mid_rx: got %h want 0000", rx_data_v[3]); end
    tick(1); cs_n_v[3] = 1'b1; tick(3); rst = 1'b0; tick(3);
    model_reset();
    w = W'($urandom);
    load_tx(3, ~w);
    frame(3, 1, w, 16'h0000, W, r0, r1);
    model_word(3, w, e0);
    nvec++;
    if ({r0, rx_data_v[3], rx_valid_v[3]} !== {e0, m_rxd[3], m_rxv[3]}) begin
      nerr++; $display("FAIL rst_mid_after: got %h/%h/%b want %h/%h/%b", r0, rx_data_v[3], rx_valid_v[3], e0, m_rxd[3], m_rxv[3]);
    end
    ack(3);
  endtask

  task automatic test_random();
    logic [W-1:0] w0, w1, r0, r1, e0, e1;
    for (int it = 0; it < 16; it++) begin
      int m, n;
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) load_tx(m, W'($urandom));
      if ($urandom_range(0, 3) == 0) load_tx(m, W'($urandom));
      nvec++;
      if (tx_ready_v[m] !== !m_txf[m]) begin nerr++; $display("FAIL rnd_tx_ready it%0d: got %b want %b", it, tx_ready_v[m], !m_txf[m]); end
      w0 = W'($urandom); w1 = W'($urandom);
      frame(m, n, w0, w1, W, r0, r1);
      model_word(m, w0, e0);
      e1 = '0;
      if (n == 2) model_word(m, w1, e1);
      nvec++;
      if ({r0, r1} !== {e0, e1}) begin nerr++; $display("FAIL rnd_miso it%0d mode%0d: got %h %h want %h %h", it, m, r0, r1, e0, e1); end
      nvec++;
      if ({rx_data_v[m], rx_valid_v[m], ovr_v[m], und_v[m]} !== {m_rxd[m], m_rxv[m], m_ovr[m], m_und[m]}) begin
        nerr++; $display("FAIL rnd_rx it%0d mode%0d: got %h/%b%b%b want %h/%b%b%b", it, m, rx_data_v[m],
          rx_valid_v[m], ovr_v[m], und_v[m], m_rxd[m], m_rxv[m], m_ovr[m], m_und[m]);
      end
      if ($urandom_range(0, 1) == 1) ack(m);
      if ($urandom_range(0, 2) == 0) clr(m);
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk_v = 4'b1100; cs_n_v = 4'hF; mosi_v = 4'h0; tx_load_v = 4'h0;
    rx_ack_v = 4'h0; clr_v = 4'h0; tx_data_v = '0;
    model_reset();
    test_reset();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
